apb_slave_mux: RTL and testbench
================================

# apb_slave_mux

APB fan-out stage directly downstream of the AHB-to-APB bridge interface. It decodes the bridge's single `psel_en`/`paddr` transfer into per-slave `psel`/`penable` strobes, and muxes the selected slave's `prdata`/`pready`/`pslverr` back to the bridge. It adds a decode-error responder for unmapped slots and a per-transfer access-phase watchdog. Neither a bad address nor a hung slave can stall the AHB side.

## Interface
Parameters:
- `NUM_SLAVES`, 3: number of attached APB slaves (1..2^SEL_BITS).
- `SEL_BITS`, 2: width of the slave-index field in `paddr`.
- `SEL_LSB`, 12: bit position of the index field LSB in `paddr`.
- `PADDR_WIDTH`, 16: APB address width.
- `APB_DATA_WIDTH`, 32: APB data width.
- `TIMEOUT_CYCLES`, 16: access-phase cycles before a forced error. 0 disables the watchdog.

Ports:
- `hclk` in 1: system clock; all state on the rising edge.
- `hreset` in 1: synchronous, active-high reset.
- `psel_en` in 1: transfer select from the bridge.
- `penable` in 1: access-phase strobe from the bridge.
- `paddr` in PADDR_WIDTH: APB address from the bridge, stable for the whole transfer.
- `pready_x` out 1: ready returned to the bridge.
- `pslverr_x` out 1: error returned to the bridge.
- `prdata_x` out APB_DATA_WIDTH: read data returned to the bridge.
- `psel_s` out NUM_SLAVES: one-hot slave selects.
- `penable_s` out 1: gated access strobe to the slaves.
- `pready_s` in NUM_SLAVES: per-slave ready.
- `pslverr_s` in NUM_SLAVES: per-slave error.
- `prdata_s` in NUM_SLAVES*APB_DATA_WIDTH: per-slave read data, slave i at bits [i*W +: W].
- `stat_clr` in 1: clears the sticky status bits.
- `stat_decerr` out 1: sticky flag, a decode error occurred.
- `stat_timeout` out 1: sticky flag, a watchdog abort occurred.
- `stat_to_slave` out SEL_BITS: index of the slave in the most recent timeout.

## Operation
- `idx = paddr[SEL_LSB +: SEL_BITS]`; `decerr = (idx >= NUM_SLAVES)`.
- FSM states: IDLE, ACCESS, DONE. Reset state is IDLE, and the watchdog counter resets to 0.
- Setup cycle: any cycle in IDLE or DONE with `psel_en=1` and `penable=0`.
  - Latch `idx_q` and `decerr_q`, and clear the counter.
  - Drive `psel_s = onehot(idx)` combinationally, unless `decerr`.
  - Next state is ACCESS.
- ACCESS:
  - `psel_s = onehot(idx_q)` unless `decerr_q`.
  - `penable_s = penable & ~decerr_q`.
  - Response, in priority order:
    - If `decerr_q`: `pready_x=1`, `pslverr_x=1`, `prdata_x=0`.
    - Else if `TIMEOUT_CYCLES!=0`, `cnt==TIMEOUT_CYCLES-1` and `pready_s[idx_q]=0`: forced abort with `pready_x=1`, `pslverr_x=1`, `prdata_x=0`.
    - Else: `pready_x = pready_s[idx_q]`, `pslverr_x = pready_s[idx_q] & pslverr_s[idx_q]`, `prdata_x = prdata_s[idx_q]`.
  - When `pready_x=1`, next state is DONE. Otherwise `cnt <= cnt+1` and stay in ACCESS.
- DONE:
  - `psel_s=0`, `penable_s=0`.
  - A setup cycle moves to ACCESS (back-to-back transfer).
  - `psel_en=0` moves to IDLE.
  - `psel_en=1` with `penable=1` (stale access) holds DONE with no response.
- IDLE with `psel_en=1` and `penable=1`: protocol violation. No select, all outputs 0, stay in IDLE.
- Outputs outside ACCESS: `pready_x=0`, `pslverr_x=0`, `prdata_x=0`, `penable_s=0`.
- Status registers:
  - `stat_decerr` sets on each decode-error response cycle.
  - `stat_timeout` sets on each forced abort, and `stat_to_slave <= idx_q` on that abort.
  - `stat_clr` clears both flags. When set and clear coincide, set wins.
  - `stat_to_slave` is not cleared by `stat_clr`.
- Counter width: `$clog2(TIMEOUT_CYCLES+1)`. It saturates and never wraps.

## Timing
- Reset values: state IDLE, `cnt=0`, `idx_q=0`, `decerr_q=0`, `stat_*=0`.
- While `hreset=1`, every output is forced to 0, including the combinational `psel_s`.
- Reset asserted mid-transfer: the slave select drops in the same cycle and the FSM returns to IDLE. No response is generated.
- Zero added latency: slave select and response are combinational, so the bridge sees `pready_s` in the same cycle.
- Decode error: response in the first ACCESS cycle, 0 wait states.
- Watchdog: the abort response appears on access cycle `TIMEOUT_CYCLES`, counting the first ACCESS cycle as 1.
  - A slave `pready` arriving in that same cycle wins and the slave's real response is returned.
- After any `pready_x=1` cycle, `psel_s` is 0 in the following cycle, independent of when the bridge drops `psel_en`.

## Test plan
- Write to `paddr=0x1004`, slave 1 ready on the first access cycle -> `psel_s=3'b010` for 2 cycles, `penable_s` high for 1 cycle, `pready_x=1` in access cycle 1, no status flags.
- Read from `0x2000`, slave 2 drives 2 wait states then `prdata=0xA5A5_5A5A` -> `pready_x` low for 2 cycles then high with `prdata_x=0xA5A5_5A5A`, and the FSM reaches DONE.
- Access to `0x3000` (idx 3, unmapped) -> `psel_s=0` and `penable_s=0` throughout; `pready_x=1`, `pslverr_x=1` in the first access cycle; `stat_decerr=1`.
- Slave 0 holds `pready=0` forever, `TIMEOUT_CYCLES=16` -> forced `pready_x=1`, `pslverr_x=1` on access cycle 16; `stat_timeout=1`, `stat_to_slave=0`; `psel_s=0` the next cycle.
- Slave 1 asserts `pready` on exactly access cycle 16 with `pslverr=0` -> OKAY response, `stat_timeout` stays 0. Then pulse `stat_clr` together with a new decode error -> `stat_decerr` stays 1.
- Assert `hreset` during the 3rd wait cycle of a slave-2 read -> `psel_s` goes 0 immediately and the FSM is in IDLE. A following clean transfer to slave 0 completes normally.

Source files
------------

// File: rtl/apb_slave_mux.sv
// APB fan-out from a single bridge port to NUM_SLAVES slaves, with a decode-error
// responder for unmapped slots and an access-phase watchdog that aborts hung slaves.
module apb_slave_mux #(
  parameter int NUM_SLAVES     = 3,
  parameter int SEL_BITS       = 2,
  parameter int SEL_LSB        = 12,
  parameter int PADDR_WIDTH    = 16,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                                 hclk,
  input  logic                                 hreset,
  input  logic                                 psel_en,
  input  logic                                 penable,
  input  logic [PADDR_WIDTH-1:0]               paddr,
  output logic                                 pready_x,
  output logic                                 pslverr_x,
  output logic [APB_DATA_WIDTH-1:0]            prdata_x,
  output logic [NUM_SLAVES-1:0]                psel_s,
  output logic                                 penable_s,
  input  logic [NUM_SLAVES-1:0]                pready_s,
  input  logic [NUM_SLAVES-1:0]                pslverr_s,
  input  logic [NUM_SLAVES*APB_DATA_WIDTH-1:0] prdata_s,
  input  logic                                 stat_clr,
  output logic                                 stat_decerr,
  output logic                                 stat_timeout,
  output logic [SEL_BITS-1:0]                  stat_to_slave
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                      r_state, w_next;
  logic [SEL_BITS-1:0]         w_idx, r_idx_q;
  logic                        w_decerr, r_decerr_q, w_setup;
  logic [CNT_W-1:0]            r_cnt;
  logic                        w_sel_rdy, w_sel_err;
  logic [APB_DATA_WIDTH-1:0]   w_sel_data;
  logic                        w_rsp_rdy, w_rsp_err, w_abort, w_dec_rsp;
  logic [APB_DATA_WIDTH-1:0]   w_rsp_data;
  logic [NUM_SLAVES-1:0]       w_psel;
  logic                        w_pen;
  logic                        r_stat_decerr, r_stat_timeout;
  logic [SEL_BITS-1:0]         r_stat_to_slave;

  function automatic logic [NUM_SLAVES-1:0] f_onehot(input logic [SEL_BITS-1:0] idx);
    logic [NUM_SLAVES-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      if (idx == SEL_BITS'(i)) v[i] = 1'b1;
    return v;
  endfunction

  assign w_idx    = paddr[SEL_LSB +: SEL_BITS];
  assign w_decerr = (32'(w_idx) >= NUM_SLAVES);
  assign w_setup  = psel_en & ~penable;

  // Response mux keyed on the latched index; unmapped indices select nothing.
  always_comb begin
    w_sel_rdy  = 1'b0;
    w_sel_err  = 1'b0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_idx_q == SEL_BITS'(i)) begin
        w_sel_rdy  = pready_s[i];
        w_sel_err  = pslverr_s[i];
        w_sel_data = prdata_s[i*APB_DATA_WIDTH +: APB_DATA_WIDTH];
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    w_psel     = '0;
    w_pen      = 1'b0;
    w_rsp_rdy  = 1'b0;
    w_rsp_err  = 1'b0;
    w_rsp_data = '0;
    w_abort    = 1'b0;
    w_dec_rsp  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_setup) begin
          w_next = ACCESS;
          if (!w_decerr) w_psel = f_onehot(w_idx);
        end
      end
      ACCESS: begin
        if (!r_decerr_q) w_psel = f_onehot(r_idx_q);
        w_pen = penable & ~r_decerr_q;
        if (r_decerr_q) begin
          w_rsp_rdy = 1'b1;
          w_rsp_err = 1'b1;
          w_dec_rsp = 1'b1;
        end else if ((TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST) && !w_sel_rdy) begin
          // A slave ready in the final watchdog cycle takes precedence over the abort.
          w_rsp_rdy = 1'b1;
          w_rsp_err = 1'b1;
          w_abort   = 1'b1;
        end else begin
          w_rsp_rdy  = w_sel_rdy;
          w_rsp_err  = w_sel_rdy & w_sel_err;
          w_rsp_data = w_sel_data;
        end
        if (w_rsp_rdy) w_next = DONE;
      end
      DONE: begin
        if (w_setup) begin
          w_next = ACCESS;
          if (!w_decerr) w_psel = f_onehot(w_idx);
        end else if (!psel_en) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state         <= IDLE;
      r_idx_q         <= '0;
      r_decerr_q      <= 1'b0;
      r_cnt           <= '0;
      r_stat_decerr   <= 1'b0;
      r_stat_timeout  <= 1'b0;
      r_stat_to_slave <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state != ACCESS) && w_setup) begin
        r_idx_q    <= w_idx;
        r_decerr_q <= w_decerr;
        r_cnt      <= '0;
      end else if ((r_state == ACCESS) && !w_rsp_rdy && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + 1'b1;
      end
      // Set has priority over clear so an event in the clear cycle is never lost.
      r_stat_decerr  <= w_dec_rsp | (r_stat_decerr & ~stat_clr);
      r_stat_timeout <= w_abort | (r_stat_timeout & ~stat_clr);
      if (w_abort) r_stat_to_slave <= r_idx_q;
    end
  end

  assign psel_s        = hreset ? '0   : w_psel;
  assign penable_s     = hreset ? 1'b0 : w_pen;
  assign pready_x      = hreset ? 1'b0 : w_rsp_rdy;
  assign pslverr_x     = hreset ? 1'b0 : w_rsp_err;
  assign prdata_x      = hreset ? '0   : w_rsp_data;
  assign stat_decerr   = hreset ? 1'b0 : r_stat_decerr;
  assign stat_timeout  = hreset ? 1'b0 : r_stat_timeout;
  assign stat_to_slave = hreset ? '0   : r_stat_to_slave;

endmodule

// File: tb/tb_apb_slave_mux.sv
// Directed bench for apb_slave_mux: normal, wait-state, decode-error, watchdog and reset cases.
module tb_apb_slave_mux;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        psel_en, penable;
  logic [15:0] paddr;
  logic        pready_x, pslverr_x;
  logic [31:0] prdata_x;
  logic [2:0]  psel_s;
  logic        penable_s;
  logic [2:0]  pready_s, pslverr_s;
  logic [95:0] prdata_s;
  logic        stat_clr, stat_decerr, stat_timeout;
  logic [1:0]  stat_to_slave;

  int nerr = 0;
  int nchk = 0;

  apb_slave_mux dut (
    .hclk(hclk), .hreset(hreset), .psel_en(psel_en), .penable(penable), .paddr(paddr),
    .pready_x(pready_x), .pslverr_x(pslverr_x), .prdata_x(prdata_x),
    .psel_s(psel_s), .penable_s(penable_s),
    .pready_s(pready_s), .pslverr_s(pslverr_s), .prdata_s(prdata_s),
    .stat_clr(stat_clr), .stat_decerr(stat_decerr), .stat_timeout(stat_timeout),
    .stat_to_slave(stat_to_slave)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge hclk);
    #1;
  endtask

  task automatic smp();
    @(negedge hclk);
  endtask

  initial begin
    hreset = 1'b1; psel_en = 1'b0; penable = 1'b0; paddr = '0;
    pready_s = '0; pslverr_s = '0; prdata_s = '0; stat_clr = 1'b0;
    adv(); adv();
    // outputs forced low during reset, even with a setup cycle on the inputs
    psel_en = 1'b1; paddr = 16'h1004;
    smp();
    chk("rst_psel",    64'(psel_s), 64'h0);
    chk("rst_pready",  64'(pready_x), 64'h0);
    chk("rst_stat",    64'({stat_decerr, stat_timeout, stat_to_slave}), 64'h0);
    adv();
    hreset = 1'b0; psel_en = 1'b0;
    adv();

    // write to slave 1, zero wait states
    psel_en = 1'b1; penable = 1'b0; paddr = 16'h1004;
    prdata_s[32 +: 32] = 32'h1111_1111;
    smp();
    chk("t1_setup_psel", 64'(psel_s), 64'h2);
    chk("t1_setup_pen",  64'(penable_s), 64'h0);
    chk("t1_setup_rdy",  64'(pready_x), 64'h0);
    adv();
    penable = 1'b1; pready_s = 3'b010;
    smp();
    chk("t1_acc_psel", 64'(psel_s), 64'h2);
    chk("t1_acc_pen",  64'(penable_s), 64'h1);
    chk("t1_acc_rsp",  64'({pready_x, pslverr_x}), 64'h2);
    chk("t1_acc_data", 64'(prdata_x), 64'h1111_1111);
    adv();
    psel_en = 1'b0; penable = 1'b0; pready_s = '0;
    smp();
    chk("t1_done_psel", 64'(psel_s), 64'h0);
    chk("t1_done_rdy",  64'(pready_x), 64'h0);
    chk("t1_flags",     64'({stat_decerr, stat_timeout}), 64'h0);
    adv();

    // read from slave 2 with two wait states; pslverr without pready must not leak
    psel_en = 1'b1; penable = 1'b0; paddr = 16'h2000;
    smp();
    chk("t2_setup_psel", 64'(psel_s), 64'h4);
    adv();
    penable = 1'b1; pslverr_s = 3'b100;
    for (int k = 1; k <= 2; k++) begin
      smp();
      chk("t2_wait_rsp",  64'({pready_x, pslverr_x}), 64'h0);
      chk("t2_wait_psel", 64'(psel_s), 64'h4);
      chk("t2_wait_pen",  64'(penable_s), 64'h1);
      adv();
    end
    pready_s = 3'b100; pslverr_s = '0; prdata_s[64 +: 32] = 32'hA5A5_5A5A;
    smp();
    chk("t2_rsp",  64'({pready_x, pslverr_x}), 64'h2);
    chk("t2_data", 64'(prdata_x), 64'hA5A5_5A5A);
    adv();
    // stale access in DONE: held with no select and no response
    pready_s = '0;
    smp();
    chk("t2_done_psel", 64'(psel_s), 64'h0);
    chk("t2_done_rsp",  64'({pready_x, penable_s}), 64'h0);
    adv();
    smp();
    chk("t2_stale_rsp", 64'({psel_s, pready_x}), 64'h0);
    adv();
    psel_en = 1'b0; penable = 1'b0;
    adv();

    // unmapped slot 3: immediate error, no strobes
    psel_en = 1'b1; paddr = 16'h3000; prdata_s = {3{32'hFFFF_FFFF}}; pready_s = 3'b111;
    smp();
    chk("t3_setup_psel", 64'(psel_s), 64'h0);
    adv();
    penable = 1'b1;
    smp();
    chk("t3_acc_sel", 64'({psel_s, penable_s}), 64'h0);
    chk("t3_acc_rsp", 64'({pready_x, pslverr_x}), 64'h3);
    chk("t3_acc_data", 64'(prdata_x), 64'h0);
    adv();
    psel_en = 1'b0; penable = 1'b0; pready_s = '0;
    smp();
    chk("t3_decerr", 64'(stat_decerr), 64'h1);
    adv();
    stat_clr = 1'b1;
    adv();
    stat_clr = 1'b0;
    smp();
    chk("t3_clr", 64'(stat_decerr), 64'h0);
    adv();

    // slave 0 hangs: watchdog abort on access cycle 16
    psel_en = 1'b1; paddr = 16'h0000; prdata_s[0 +: 32] = 32'hDEAD_BEEF;
    adv();
    penable = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      smp();
      chk("t4_wait_rdy", 64'(pready_x), 64'h0);
      adv();
    end
    smp();
    chk("t4_abort_rsp",  64'({pready_x, pslverr_x}), 64'h3);
    chk("t4_abort_data", 64'(prdata_x), 64'h0);
    chk("t4_abort_psel", 64'(psel_s), 64'h1);
    adv();
    smp();
    chk("t4_after_psel", 64'(psel_s), 64'h0);
    chk("t4_stat",       64'({stat_timeout, stat_to_slave}), 64'h4);
    adv();
    psel_en = 1'b0; penable = 1'b0; stat_clr = 1'b1;
    adv();
    stat_clr = 1'b0;
    smp();
    chk("t4_clr", 64'(stat_timeout), 64'h0);
    adv();

    // slave 1 ready exactly on cycle 16 wins over the watchdog
    psel_en = 1'b1; paddr = 16'h1000; prdata_s[32 +: 32] = 32'h1234_5678;
    adv();
    penable = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      smp();
      chk("t5_wait_rdy", 64'(pready_x), 64'h0);
      adv();
    end
    pready_s = 3'b010;
    smp();
    chk("t5_rsp",  64'({pready_x, pslverr_x}), 64'h2);
    chk("t5_data", 64'(prdata_x), 64'h1234_5678);
    adv();
    psel_en = 1'b0; penable = 1'b0; pready_s = '0;
    smp();
    chk("t5_no_timeout", 64'(stat_timeout), 64'h0);
    adv();
    // clear pulse coinciding with a decode-error response: set wins
    psel_en = 1'b1; paddr = 16'h3ABC;
    adv();
    penable = 1'b1; stat_clr = 1'b1;
    smp();
    chk("t5_dec_rsp", 64'({pready_x, pslverr_x}), 64'h3);
    adv();
    stat_clr = 1'b0; psel_en = 1'b0; penable = 1'b0;
    smp();
    chk("t5_set_wins", 64'(stat_decerr), 64'h1);
    adv();

    // slave 2 timeout records index 2; index survives a clear
    psel_en = 1'b1; paddr = 16'h2FFC;
    adv();
    penable = 1'b1;
    for (int k = 1; k <= 15; k++) adv();
    smp();
    chk("t6_abort_rsp", 64'({pready_x, pslverr_x}), 64'h3);
    adv();
    psel_en = 1'b0; penable = 1'b0;
    smp();
    chk("t6_stat", 64'({stat_timeout, stat_to_slave}), 64'h6);
    adv();
    stat_clr = 1'b1;
    adv();
    stat_clr = 1'b0;
    smp();
    chk("t6_clr", 64'({stat_decerr, stat_timeout, stat_to_slave}), 64'h2);
    adv();

    // reset during the 3rd wait cycle of a slave-2 read
    psel_en = 1'b1; paddr = 16'h2000;
    adv();
    penable = 1'b1;
    adv(); adv();
    hreset = 1'b1;
    smp();
    chk("t7_rst_sel", 64'({psel_s, penable_s, pready_x}), 64'h0);
    adv();
    hreset = 1'b0;
    // IDLE with penable high is a protocol violation: no select
    smp();
    chk("t7_idle_viol", 64'({psel_s, pready_x, pslverr_x}), 64'h0);
    adv();
    psel_en = 1'b0; penable = 1'b0;
    adv();
    // clean transfer to slave 0 with an error response passed through
    psel_en = 1'b1; paddr = 16'h0010; prdata_s[0 +: 32] = 32'hCAFE_F00D;
    smp();
    chk("t7_setup_psel", 64'(psel_s), 64'h1);
    adv();
    penable = 1'b1; pready_s = 3'b001; pslverr_s = 3'b001;
    smp();
    chk("t7_rsp",  64'({pready_x, pslverr_x}), 64'h3);
    chk("t7_data", 64'(prdata_x), 64'hCAFE_F00D);
    chk("t7_pen",  64'(penable_s), 64'h1);
    adv();
    psel_en = 1'b0; penable = 1'b0; pready_s = '0; pslverr_s = '0;
    smp();
    chk("t7_done", 64'({psel_s, pready_x, stat_timeout}), 64'h0);
    adv();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
